// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state encoding,
// parity selections and the default bit period.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEF_CLKS_PER_BIT = 434;

  // Parity bit that goes on the line for a given byte and parity selection.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Shared by the transmitter and receiver.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  // Free-running bit-cycle count with synchronous clear and wrap at LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txd_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       txd_busy,
  output logic       txd_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     state;
  logic [7:0] shreg;
  logic       par_bit;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic       bit_end;
  logic       cnt_clr;

  // Holding the counter at zero while idle means it starts fresh on acceptance.
  assign cnt_clr = (state == S_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .bit_end(bit_end)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      txd_busy <= 1'b0;
      txd_done <= 1'b0;
    end else begin
      txd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (txd_start) begin
            shreg    <= tx_data;
            par_bit  <= parity_bit(tx_data, PARITY);
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
            txd      <= 1'b0;
            txd_busy <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            txd   <= shreg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                txd   <= par_bit;
                state <= S_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              // Drive the next bit straight from the pre-shift value.
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            txd   <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              txd_busy <= 1'b0;
              txd_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd      <= 1'b1;
          txd_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4: four instances cover the
// parity and stop-bit variants; frames are compared bit by bit per cycle.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = 4'b0000;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] txd_v, busy_v, done_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: no parity/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: no parity/2 stop
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .txd_start(start_v[0]), .tx_data(tx_data),
    .txd(txd_v[0]), .txd_busy(busy_v[0]), .txd_done(done_v[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .txd_start(start_v[1]), .tx_data(tx_data),
    .txd(txd_v[1]), .txd_busy(busy_v[1]), .txd_done(done_v[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .txd_start(start_v[2]), .tx_data(tx_data),
    .txd(txd_v[2]), .txd_busy(busy_v[2]), .txd_done(done_v[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .txd_start(start_v[3]), .tx_data(tx_data),
    .txd(txd_v[3]), .txd_busy(busy_v[3]), .txd_done(done_v[3]));

  // frame holds the line bits in transmission order in its low nbits bits
  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs[8];
  logic [11:0] wrap_frames[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic start_frame(input int sel, input logic [7:0] d);
    start_v[sel] = 1'b1;
    tx_data = d;
    tick();
    start_v[sel] = 1'b0;
    tx_data = ~d;
  endtask

  // Entered just after acceptance edge E; returns just after edge E+N,
  // or just after the reset edge when abort_at is used.
  task automatic check_frame(input int sel, input logic [11:0] frame, input int nbits,
                             input int inject_at, input int abort_at);
    int n;
    n = nbits * CPB;
    for (int c = 0; c < n; c++) begin
      check("txd", c, txd_v[sel], frame[nbits - 1 - c / CPB]);
      check("busy", c, busy_v[sel], 1'b1);
      check("done_low", c, done_v[sel], 1'b0);
      if (c == inject_at) begin
        start_v[sel] = 1'b1;
        tx_data = 8'h3C;
      end
      if (c == inject_at + 1) begin
        start_v[sel] = 1'b0;
      end
      if (c == abort_at) begin
        rst = 1'b1;
        tick();
        check("abort_txd", c + 1, txd_v[sel], 1'b1);
        check("abort_busy", c + 1, busy_v[sel], 1'b0);
        check("abort_done", c + 1, done_v[sel], 1'b0);
        return;
      end
      tick();
    end
    check("end_busy", n, busy_v[sel], 1'b0);
    check("end_done", n, done_v[sel], 1'b1);
    check("end_txd", n, txd_v[sel], 1'b1);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 12'b0101001011,  10};
    vecs[1] = '{0, 8'h00, 12'b0000000001,  10};
    vecs[2] = '{0, 8'h80, 12'b0000000011,  10};
    vecs[3] = '{1, 8'h07, 12'b01110000011, 11};
    vecs[4] = '{2, 8'h07, 12'b01110000001, 11};
    vecs[5] = '{1, 8'h00, 12'b00000000001, 11};
    vecs[6] = '{2, 8'h01, 12'b01000000001, 11};
    vecs[7] = '{3, 8'hFF, 12'b01111111111, 11};
    wrap_frames[0] = 12'b0100000001;
    wrap_frames[1] = 12'b0010000001;
    wrap_frames[2] = 12'b0110000001;
    wrap_frames[3] = 12'b0001000001;
    wrap_frames[4] = 12'b0101000001;
    wrap_frames[5] = 12'b0011000001;

    // Reset state on every instance
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("rst_txd", 0, txd_v[k], 1'b1);
      check("rst_busy", 0, busy_v[k], 1'b0);
      check("rst_done", 0, done_v[k], 1'b0);
    end
    rst = 1'b0;
    tick();

    // Single frames from the table
    for (int i = 0; i < 8; i++) begin
      start_frame(vecs[i].sel, vecs[i].data);
      check_frame(vecs[i].sel, vecs[i].frame, vecs[i].nbits, -1, -1);
      tick();
      check("post_done", 0, done_v[vecs[i].sel], 1'b0);
      check("post_busy", 0, busy_v[vecs[i].sel], 1'b0);
      tick();
    end

    // Start strobe while mid-DATA is ignored and not queued
    start_frame(0, 8'hA5);
    check_frame(0, 12'b0101001011, 10, 20, -1);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("noqueue_busy", c, busy_v[0], 1'b0);
      check("noqueue_txd", c, txd_v[0], 1'b1);
      check("noqueue_done", c, done_v[0], 1'b0);
    end

    // Wrapper sequence: six bytes, each started the first cycle busy is low
    for (int k = 0; k < 6; k++) begin
      start_frame(0, 8'(k + 1));
      check_frame(0, wrap_frames[k], 10, -1, -1);
    end
    tick();
    check("wrap_idle_done", 0, done_v[0], 1'b0);
    check("wrap_idle_busy", 0, busy_v[0], 1'b0);

    // Reset during DATA bit 3, then a full frame
    start_frame(0, 8'hA5);
    check_frame(0, 12'b0101001011, 10, -1, 17);
    rst = 1'b0;
    tick();
    check("rel_done", 0, done_v[0], 1'b0);
    check("rel_busy", 0, busy_v[0], 1'b0);
    start_frame(0, 8'h3C);
    check_frame(0, 12'b0001111001, 10, -1, -1);
    tick();

    // Reset wins over a simultaneous start
    rst = 1'b1;
    start_v[0] = 1'b1;
    tx_data = 8'h55;
    tick();
    start_v[0] = 1'b0;
    rst = 1'b0;
    check("rst_start_busy", 0, busy_v[0], 1'b0);
    check("rst_start_txd", 0, txd_v[0], 1'b1);
    tick();
    check("rst_start_busy2", 1, busy_v[0], 1'b0);
    check("rst_start_txd2", 1, txd_v[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
